// File: rtl/rv_inst_encoder_if.sv
// Request/response bus of the RV64I/M instruction encoder.
// Requester and consumer sit on the master side; the encoder sits on the slave side.
interface rv_inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_last;
    logic        out_err;

    modport master (
        output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_last, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_last, out_err
    );
endinterface

// File: rtl/rv_inst_encoder.sv
// Streaming RV64I/M instruction encoder with LI pseudo-op expansion.
// One registered output word; a pending ADDIW/ADDI of an LI pair is held in SECOND.
module rv_inst_encoder #(
    parameter int XLEN      = 64,
    parameter bit CHECK_IMM = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    rv_inst_encoder_if.slave   bus
);
    typedef enum logic {IDLE, SECOND} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic        last;
        logic        err;
    } word_t;

    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LO   = (XLEN == 64) ? 7'b0011011 : OP_ADDI;

    state_t state, nxt_state;
    word_t  out_q, nxt_out;
    word_t  sec_q, nxt_sec;
    logic   out_vld, nxt_vld;
    logic   in_rdy;

    // ---- combinational encode of the presented request
    word_t       enc, enc_sec;
    logic        enc_two, bad, rsvd;
    logic        fits12, fits_b, fits_j;
    logic [19:0] li_hi;
    logic signed [31:0] imm_s;
    logic [31:0] imm;

    assign imm    = bus.in_imm;
    assign imm_s  = bus.in_imm;
    assign fits12 = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    assign fits_b = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm[0];
    assign fits_j = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm[0];
    // (imm + 0x800) >> 12: the 0x800 carries into bit 12 exactly when imm[11] is set
    assign li_hi  = imm[31:12] + {19'd0, imm[11]};

    always_comb begin
        enc     = '0;
        enc_sec = '0;
        enc_two = 1'b0;
        bad     = 1'b0;
        rsvd    = 1'b0;
        unique case (bus.in_fmt)
            3'd0: enc.inst = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                              bus.in_rd, bus.in_opcode};
            3'd1: begin
                enc.inst = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
                bad      = !fits12;
            end
            3'd2: begin
                enc.inst = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            imm[4:0], bus.in_opcode};
                bad      = !fits12;
            end
            3'd3: begin
                enc.inst = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            imm[4:1], imm[11], bus.in_opcode};
                bad      = !fits_b;
            end
            3'd4: enc.inst = {imm[19:0], bus.in_rd, bus.in_opcode};
            3'd5: begin
                enc.inst = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
                bad      = !fits_j;
            end
            3'd6: begin
                if (fits12) begin
                    enc.inst = {imm[11:0], 5'd0, 3'b000, bus.in_rd, OP_ADDI};
                end else begin
                    enc.inst = {li_hi, bus.in_rd, OP_LUI};
                    // low part equals imm[11:0] reinterpreted as signed 12 bits
                    if (imm[11:0] != 12'd0) begin
                        enc_two      = 1'b1;
                        enc_sec.inst = {imm[11:0], bus.in_rd, 3'b000, bus.in_rd, OP_LO};
                        enc_sec.last = 1'b1;
                    end
                end
            end
            default: rsvd = 1'b1;
        endcase
        enc.last = !enc_two;
        if (rsvd || (CHECK_IMM && bad)) begin
            enc     = '{inst: 32'h0, last: 1'b1, err: 1'b1};
            enc_two = 1'b0;
        end
    end

    // ---- next-state / output register control
    always_comb begin
        nxt_state = state;
        nxt_out   = out_q;
        nxt_sec   = sec_q;
        nxt_vld   = out_vld;
        in_rdy    = (state == IDLE) && (!out_vld || bus.out_ready);
        if (bus.in_valid && in_rdy) begin
            nxt_out = enc;
            nxt_vld = 1'b1;
            if (enc_two) begin
                nxt_state = SECOND;
                nxt_sec   = enc_sec;
            end
        end else if (state == SECOND && bus.out_ready) begin
            nxt_out   = sec_q;
            nxt_state = IDLE;
        end else if (out_vld && bus.out_ready) begin
            nxt_vld = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            out_q   <= '0;
            sec_q   <= '0;
            out_vld <= 1'b0;
        end else begin
            state   <= nxt_state;
            out_q   <= nxt_out;
            sec_q   <= nxt_sec;
            out_vld <= nxt_vld;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_inst  = out_q.inst;
    assign bus.out_last  = out_q.last;
    assign bus.out_err   = out_q.err;
endmodule

// File: tb/tb_rv_inst_encoder.sv
// Scoreboard bench for rv_inst_encoder: directed vectors plus randomized requests
// against a behavioural model; a monitor checks every output handshake.
module tb_rv_inst_encoder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rv_inst_encoder_if bus();

    rv_inst_encoder #(.XLEN(64), .CHECK_IMM(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
    } req_t;

    typedef struct {
        logic [31:0] inst;
        logic        last;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t stg[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   force_stall = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic void push_w(logic [31:0] inst, logic last, logic err);
        exp_t e;
        e.inst = inst; e.last = last; e.err = err;
        stg.push_back(e);
    endfunction

    // Reference model: expected word list for one request.
    function automatic void model_push(req_t r);
        int v;
        logic [31:0] hi32, lo32;
        v = int'($signed(r.imm));
        case (r.fmt)
            3'd0: push_w({r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op}, 1'b1, 1'b0);
            3'd1: if (v < -2048 || v > 2047) push_w(32'h0, 1'b1, 1'b1);
                  else push_w({r.imm[11:0], r.rs1, r.f3, r.rd, r.op}, 1'b1, 1'b0);
            3'd2: if (v < -2048 || v > 2047) push_w(32'h0, 1'b1, 1'b1);
                  else push_w({r.imm[11:5], r.rs2, r.rs1, r.f3, r.imm[4:0], r.op}, 1'b1, 1'b0);
            3'd3: if (v < -4096 || v > 4094 || r.imm[0]) push_w(32'h0, 1'b1, 1'b1);
                  else push_w({r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.f3, r.imm[4:1],
                               r.imm[11], r.op}, 1'b1, 1'b0);
            3'd4: push_w({r.imm[19:0], r.rd, r.op}, 1'b1, 1'b0);
            3'd5: if (v < -1048576 || v > 1048574 || r.imm[0]) push_w(32'h0, 1'b1, 1'b1);
                  else push_w({r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.op},
                              1'b1, 1'b0);
            3'd6: begin
                if (v >= -2048 && v <= 2047) begin
                    push_w({r.imm[11:0], 5'd0, 3'b000, r.rd, 7'h13}, 1'b1, 1'b0);
                end else begin
                    hi32 = (r.imm + 32'h800) >> 12;
                    lo32 = r.imm - (hi32 << 12);
                    push_w({hi32[19:0], r.rd, 7'h37}, (lo32 == 32'h0), 1'b0);
                    if (lo32 != 32'h0)
                        push_w({lo32[11:0], r.rd, 3'b000, r.rd, 7'h1B}, 1'b1, 1'b0);
                end
            end
            default: push_w(32'h0, 1'b1, 1'b1);
        endcase
    endfunction

    function automatic req_t mk(logic [2:0] fmt, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm);
        req_t r;
        r.fmt = fmt; r.op = op; r.f3 = f3; r.f7 = f7;
        r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(req_t r, bit use_model);
        int t = 0;
        if (use_model) model_push(r);
        bus.in_fmt = r.fmt; bus.in_opcode = r.op; bus.in_funct3 = r.f3; bus.in_funct7 = r.f7;
        bus.in_rd = r.rd; bus.in_rs1 = r.rs1; bus.in_rs2 = r.rs2; bus.in_imm = r.imm;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            t++;
            if (t > 300) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        while (stg.size() > 0) q.push_back(stg.pop_front());
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        forever begin
            @(negedge clk);
            if (q.size() == 0 && !bus.out_valid) break;
            t++;
            if (t > 500) begin
                chk("drain_timeout", 32'(q.size()), 32'd0);
                q.delete();
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Consumer ready: random, or held low on request.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = force_stall ? 1'b0 : ($urandom_range(3) != 0);
        end
    end

    // Monitor: scoreboard pop on each handshake, hold stability and in_ready checks.
    exp_t held;
    bit   held_v = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            held_v = 1'b0;
        end else begin
            chk("in_ready", 32'(bus.in_ready),
                32'(!bus.out_valid || (bus.out_ready && bus.out_last)));
            if (held_v) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_inst", bus.out_inst, held.inst);
                chk("hold_last", 32'(bus.out_last), 32'(held.last));
            end
            held_v    = bus.out_valid && !bus.out_ready;
            held.inst = bus.out_inst;
            held.last = bus.out_last;
            held.err  = bus.out_err;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", bus.out_inst, 32'hxxxxxxxx);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_inst", bus.out_inst, e.inst);
                    chk("out_last", 32'(bus.out_last), 32'(e.last));
                    chk("out_err", 32'(bus.out_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    localparam int NB = 15;
    int bnd [NB] = '{-2049, -2048, 2047, 2048, -4096, -4098, 4094, 4096, 4095,
                     -1048576, -1048578, 1048574, 1048576, 0, 1};

    initial begin
        req_t r;
        bus.in_valid = 1'b0; bus.in_fmt = '0; bus.in_opcode = '0; bus.in_funct3 = '0;
        bus.in_funct7 = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
        #12;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_inst", bus.out_inst, 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        chk("rst_err", 32'(bus.out_err), 32'd0);
        #20 reset_n = 1'b1;
        @(posedge clk); #1;

        // add a0,a1,a2 with 1-clk latency
        push_w(32'h00C58533, 1'b1, 1'b0);
        issue(mk(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd10, 5'd11, 5'd12, 32'd0), 1'b0);
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_inst", bus.out_inst, 32'h00C58533);
        drain();

        push_w(32'h12345537, 1'b0, 1'b0); push_w(32'h6785051B, 1'b1, 1'b0);
        issue(mk(3'd6, 7'd0, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h12345678), 1'b0);
        push_w(32'h00001537, 1'b0, 1'b0); push_w(32'h8005051B, 1'b1, 1'b0);
        issue(mk(3'd6, 7'd0, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'd2048), 1'b0);
        push_w(32'h00001537, 1'b1, 1'b0);
        issue(mk(3'd6, 7'd0, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h1000), 1'b0);
        push_w(32'hFFF00513, 1'b1, 1'b0);
        issue(mk(3'd6, 7'd0, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'hFFFFFFFF), 1'b0);
        push_w(32'hFE208EE3, 1'b1, 1'b0);
        issue(mk(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4), 1'b0);
        push_w(32'h0, 1'b1, 1'b1);
        issue(mk(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3), 1'b0);
        push_w(32'h0, 1'b1, 1'b1);
        issue(mk(3'd7, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0), 1'b0);
        drain();

        // consumer stalled 5 clks under back-to-back requests
        @(negedge clk); force_stall = 1'b1;
        @(posedge clk); #1;
        fork
            begin
                issue(mk(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hABCDE123), 1'b1);
                issue(mk(3'd1, 7'h13, 3'd2, 7'd0, 5'd6, 5'd7, 5'd0, 32'd100), 1'b1);
                issue(mk(3'd2, 7'h23, 3'd3, 7'd0, 5'd0, 5'd8, 5'd9, -32'sd2048), 1'b1);
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk); force_stall = 1'b0;
            end
        join
        drain();

        // reset while an LI pair is pending
        @(negedge clk); force_stall = 1'b1;
        @(posedge clk); #1;
        issue(mk(3'd6, 7'd0, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h12345678), 1'b1);
        chk("second_lui", bus.out_inst, 32'h12345537);
        chk("second_last", 32'(bus.out_last), 32'd0);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_inst", bus.out_inst, 32'd0);
        chk("mid_rst_last", 32'(bus.out_last), 32'd0);
        q.delete();
        force_stall = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        push_w(32'h00C58533, 1'b1, 1'b0);
        issue(mk(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd10, 5'd11, 5'd12, 32'd0), 1'b0);
        drain();

        // randomized requests
        for (int i = 0; i < 400; i++) begin
            r.fmt = 3'($urandom_range(7));
            r.op  = 7'($urandom); r.f3 = 3'($urandom); r.f7 = 7'($urandom);
            r.rd  = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
            case ($urandom_range(5))
                0: r.imm = 32'($signed($urandom_range(4095)) - 2048);
                1: r.imm = 32'(bnd[$urandom_range(NB - 1)]);
                2: r.imm = $urandom;
                3: r.imm = 32'(($signed($urandom_range(4095)) - 2048) * 2);
                4: r.imm = 32'(($signed($urandom_range(1048575)) - 524288) * 2);
                default: r.imm = {$urandom_range(1) ? 20'($urandom) : 20'h0, 12'($urandom)};
            endcase
            issue(r, 1'b1);
            if ($urandom_range(7) == 0) begin
                repeat ($urandom_range(3)) @(posedge clk);
                #1;
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
